// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_bank
// Brief    : Bank of CHANNELS independent WIDTH-bit event counters. Each
//            channel has a sticky overflow flag. Overflow either wraps or
//            saturates, selected by sat_mode. Reads have a fixed latency of
//            one cycle.
// Options  : PERF_CNT_SNAPSHOT_EN - when defined, snap copies every counter
//            into a shadow register and reads return the shadow values. When
//            undefined, snap is ignored and reads return the live counters.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_bank #(
   parameter int WIDTH    = 64,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,        // asynchronous, active-low
   input  logic [CHANNELS-1:0] inc,
   input  logic [CHANNELS-1:0] clear,
   input  logic                clear_all,
   input  logic                sat_mode,
   input  logic                snap,
   input  logic                rd_req,
   input  logic [SEL_W-1:0]    rd_sel,
   output logic                rd_valid,
   output logic [WIDTH-1:0]    rd_data,
   output logic [CHANNELS-1:0] ovf
);

   // Full-width +1 keeps the adder free of narrow-constant truncation.
   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   logic [WIDTH-1:0] w_rd_src [CHANNELS];
   logic [WIDTH-1:0] w_rd_val;
   logic             r_rd_valid;
   logic [WIDTH-1:0] r_rd_data;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [WIDTH-1:0] r_cnt;
         logic             r_ovf;
         logic             w_at_max;

         assign w_at_max = &r_cnt;

         // Counter and sticky overflow: clear_all, then clear[i], then inc[i].
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_cnt <= '0;
               r_ovf <= 1'b0;
            end else if (clear_all || clear[gi]) begin
               r_cnt <= '0;
               r_ovf <= 1'b0;
            end else if (inc[gi]) begin
               if (w_at_max) begin
                  r_ovf <= 1'b1;
                  r_cnt <= sat_mode ? r_cnt : '0;
               end else begin
                  r_cnt <= r_cnt + c_one;
               end
            end
         end

         assign ovf[gi] = r_ovf;

`ifdef PERF_CNT_SNAPSHOT_EN
         logic [WIDTH-1:0] r_shadow;

         // Shadow takes the pre-update counter value and ignores all clears.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_shadow <= '0;
            end else if (snap) begin
               r_shadow <= r_cnt;
            end
         end

         assign w_rd_src[gi] = r_shadow;
`else
         assign w_rd_src[gi] = r_cnt;
`endif
      end
   endgenerate

`ifndef PERF_CNT_SNAPSHOT_EN
   // The snap input has no function in this build.
   logic w_unused_snap;
   assign w_unused_snap = snap;
`endif

   // Read mux: an index with no matching channel yields zero.
   always_comb begin
      w_rd_val = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (rd_sel == SEL_W'(k)) begin
            w_rd_val = w_rd_src[k];
         end
      end
   end

   // Read port register: one-cycle valid pulse, data held between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= rd_req;
         if (rd_req) begin
            r_rd_data <= w_rd_val;
         end
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;

endmodule
`default_nettype wire
